// File: rtl/pcm_pkg.sv
// Shared constants and types for the PCM serial-capture monitors.
package pcm_pkg;

  localparam int PCM1702_W       = 20;
  localparam int PCM2706_W       = 16;
  localparam int ERR_CNT_W       = 8;
  localparam int LOCK_GOOD_WORDS = 2;

  typedef enum logic {
    ALIGN = 1'b0,
    RUN   = 1'b1
  } cap_state_e;

  function automatic logic [ERR_CNT_W-1:0] sat_inc_err(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/pcm1702_capture_edge_sync.sv
// N-stage input synchronizer with single-cycle rise/fall pulses on the synchronized value.
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~hist_q;
  assign fall_o = ~q_o & hist_q;

endmodule

// File: rtl/pcm1702_capture.sv
// Deserializes the PCM1702 BCK/DATA/LE stream, checks word framing and measures word period.
// Optional peak-magnitude tracker enabled by defining PCM1702_CAPTURE_PEAK_EN.
module pcm1702_capture
  import pcm_pkg::*;
#(
  parameter int DATA_W      = PCM1702_W,
  parameter int SYNC_STAGES = 2,
  parameter int PERIOD_W    = 12
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 bck_in,
  input  logic                 data_in,
  input  logic                 le_in,
  output logic [DATA_W-1:0]    sample_out,
  output logic                 sample_valid,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [PERIOD_W-1:0]  word_period,
  output logic                 locked
`ifdef PCM1702_CAPTURE_PEAK_EN
  ,
  input  logic                 peak_clr,
  output logic [DATA_W-2:0]    peak_abs
`endif
);

  localparam int               CNT_W    = $clog2(DATA_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DATA_W + 1);
  localparam logic [1:0]       GOOD_SAT = 2'(LOCK_GOOD_WORDS);

  logic bck_s, bck_rise, bck_fall;
  logic data_s, data_rise, data_fall;
  logic le_s, le_rise, le_fall;

  edge_sync #(.STAGES(SYNC_STAGES)) u_bck (
    .clk_i(CLK), .rst_i(RST), .d_i(bck_in),
    .q_o(bck_s), .rise_o(bck_rise), .fall_o(bck_fall));
  edge_sync #(.STAGES(SYNC_STAGES)) u_data (
    .clk_i(CLK), .rst_i(RST), .d_i(data_in),
    .q_o(data_s), .rise_o(data_rise), .fall_o(data_fall));
  edge_sync #(.STAGES(SYNC_STAGES)) u_le (
    .clk_i(CLK), .rst_i(RST), .d_i(le_in),
    .q_o(le_s), .rise_o(le_rise), .fall_o(le_fall));

  logic unused_edges;
  assign unused_edges = ^{bck_s, bck_fall, data_rise, data_fall, le_s, le_rise};

  cap_state_e          state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d, bits_seen;
  logic                close_good, close_bad;
  logic [PERIOD_W-1:0] period_cnt_q, word_period_q;
  logic                period_sat;
  logic                good_pend_q, bad_pend_q, oor_pend_q;
  logic [DATA_W-1:0]   word_pend_q, sample_q;
  logic                valid_q, ferr_q, locked_q;
  logic [ERR_CNT_W-1:0] err_q;
  logic [1:0]          good_cnt_q;

  // A BCK rise coinciding with the closing LE fall is shifted in before the word closes.
  always_comb begin
    shreg_d   = bck_rise ? {shreg_q[DATA_W-2:0], data_s} : shreg_q;
    bits_seen = (bck_rise && bit_cnt_q != CNT_SAT) ? bit_cnt_q + 1'b1 : bit_cnt_q;
    bit_cnt_d = le_fall ? '0 : bits_seen;
  end

  assign period_sat = &period_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ALIGN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ALIGN && le_fall) state_d = RUN;
  end

  always_comb begin
    close_good = (state_q == RUN) && le_fall && (bits_seen == CNT_FULL);
    close_bad  = (state_q == RUN) && le_fall && (bits_seen != CNT_FULL);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      period_cnt_q  <= '0;
      word_period_q <= '0;
      good_pend_q   <= 1'b0;
      bad_pend_q    <= 1'b0;
      oor_pend_q    <= 1'b0;
      word_pend_q   <= '0;
    end else begin
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      good_pend_q <= close_good;
      bad_pend_q  <= close_bad;
      oor_pend_q  <= le_fall && period_sat;
      if (close_good) word_pend_q <= shreg_d;
      if (le_fall) begin
        word_period_q <= period_cnt_q;
        period_cnt_q  <= PERIOD_W'(1);
      end else if (!period_sat) begin
        period_cnt_q <= period_cnt_q + 1'b1;
      end
    end
  end

  // Results land one cycle after the close so sample_out and sample_valid move together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sample_q   <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      err_q      <= '0;
      good_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      valid_q <= good_pend_q;
      ferr_q  <= bad_pend_q;
      if (good_pend_q) sample_q <= word_pend_q;
      if (bad_pend_q)  err_q    <= sat_inc_err(err_q);
      if (bad_pend_q || oor_pend_q || period_sat) begin
        good_cnt_q <= '0;
        locked_q   <= 1'b0;
      end else if (good_pend_q) begin
        if (good_cnt_q != GOOD_SAT) good_cnt_q <= good_cnt_q + 1'b1;
        if (good_cnt_q >= GOOD_SAT - 2'd1) locked_q <= 1'b1;
      end
    end
  end

  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign frame_err    = ferr_q;
  assign err_count    = err_q;
  assign word_period  = word_period_q;
  assign locked       = locked_q;

`ifdef PCM1702_CAPTURE_PEAK_EN
  logic [DATA_W-2:0] peak_q;
  logic [DATA_W-1:0] neg_word;
  logic [DATA_W-2:0] word_abs;

  // The most negative code has no positive twin; clamp its magnitude to full scale.
  always_comb begin
    neg_word = '0 - word_pend_q;
    if (!word_pend_q[DATA_W-1]) word_abs = word_pend_q[DATA_W-2:0];
    else if (neg_word[DATA_W-1]) word_abs = '1;
    else                         word_abs = neg_word[DATA_W-2:0];
  end

  always_ff @(posedge CLK) begin
    if (RST || peak_clr)                       peak_q <= '0;
    else if (good_pend_q && word_abs > peak_q) peak_q <= word_abs;
  end

  assign peak_abs = peak_q;
`endif

endmodule

// File: tb/tb_pcm1702_capture.sv
// Randomized self-checking bench for pcm1702_capture against a word-level reference model.
module tb_pcm1702_capture;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        bck_in = 1'b0, data_in = 1'b0, le_in = 1'b0;
  logic [19:0] sample_out;
  logic        sample_valid, frame_err, locked;
  logic [7:0]  err_count;
  logic [11:0] word_period;
`ifdef PCM1702_CAPTURE_PEAK_EN
  logic        peak_clr = 1'b0;
  logic [18:0] peak_abs;
`endif

  pcm1702_capture dut (
    .CLK(CLK), .RST(RST), .bck_in(bck_in), .data_in(data_in), .le_in(le_in),
    .sample_out(sample_out), .sample_valid(sample_valid), .frame_err(frame_err),
    .err_count(err_count), .word_period(word_period), .locked(locked)
`ifdef PCM1702_CAPTURE_PEAK_EN
    , .peak_clr(peak_clr), .peak_abs(peak_abs)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc = cyc + 1;

  int n_vec = 0, n_err = 0;

  // reference model state
  bit          m_aligned, m_locked, have_prev;
  int          m_run, m_err, last_fall;
  logic [19:0] m_sample;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; bck_in = 1'b0; data_in = 1'b0; le_in = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    m_aligned = 0; m_locked = 0; have_prev = 0;
    m_run = 0; m_err = 0; m_sample = '0; last_fall = cyc;
  endtask

  // Send nbits of w (MSB first), close with LE fall, then check the response window.
  task automatic send_word(input logic [31:0] w, input int nbits, input bit coinc, input int period);
    int lat, vcnt, ecnt, diff;
    bit exp_v, exp_e;
    le_in = 1'b1;
    for (int i = nbits - 1; i >= 0; i--) begin
      data_in = w[i];
      bck_in  = 1'b0;
      tick(); tick();
      bck_in = 1'b1;
      if (!(coinc && i == 0)) begin tick(); tick(); end
    end
    if (!coinc && period > 0) while (cyc - last_fall < period) tick();
    le_in = 1'b0;
    diff = cyc - last_fall;
    last_fall = cyc;
    lat = 0; vcnt = 0; ecnt = 0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (sample_valid) begin vcnt++; if (lat == 0) lat = n; end
      if (frame_err)    begin ecnt++; if (lat == 0) lat = n; end
    end
    exp_v = 0; exp_e = 0;
    if (!m_aligned) begin
      m_aligned = 1;
    end else if (nbits == 20) begin
      exp_v = 1;
      m_sample = w[19:0];
      if (diff >= 4095) begin m_run = 0; m_locked = 0; end
      else begin m_run++; if (m_run >= 2) m_locked = 1; end
    end else begin
      exp_e = 1;
      if (m_err < 255) m_err++;
      m_run = 0; m_locked = 0;
    end
    chk("valid_pulses", vcnt, exp_v);
    chk("ferr_pulses", ecnt, exp_e);
    if (exp_v || exp_e) chk("latency", lat, 4);
    chk("sample_out", sample_out, m_sample);
    chk("err_count", err_count, m_err);
    chk("locked", locked, m_locked);
    if (have_prev) chk("word_period", word_period, (diff > 4095) ? 4095 : diff);
    have_prev = 1;
  endtask

  task automatic idle(input int n);
    int cnt = 0;
    le_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (sample_valid || frame_err) cnt++;
    end
    chk("idle_quiet", cnt, 0);
    if (cyc - last_fall >= 4095) begin m_locked = 0; m_run = 0; end
    chk("idle_locked", locked, m_locked);
  endtask

  initial begin
    do_reset();
    chk("rst_sample", sample_out, 0);
    chk("rst_valid", sample_valid, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_errcnt", err_count, 0);
    chk("rst_period", word_period, 0);
    chk("rst_locked", locked, 0);

    send_word(32'h80001, 20, 0, 0);
    send_word(32'h7FFFF, 20, 0, 0);
    send_word(32'hABCDE, 20, 0, 0);
    send_word(32'h12345, 20, 0, 0);
    send_word(32'hFFFFF, 20, 0, 0);
    send_word(32'h55555, 19, 0, 0);
    send_word(32'h0F0F0, 20, 0, 0);
    send_word(32'h3C3C3, 20, 0, 0);
    send_word(32'h1ABCD, 21, 0, 0);
    send_word(32'h00001, 20, 1, 0);
    send_word(32'hFEDCB, 20, 1, 0);

    for (int k = 0; k < 4; k++) send_word($urandom & 32'hFFFFF, 20, 0, 640);
    chk("period_640", word_period, 640);
    idle(5000);
    send_word(32'h24680, 20, 0, 0);
    chk("period_sat", word_period, 4095);

    // partial word cut short by reset
    le_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      data_in = i[0]; bck_in = 1'b0; tick(); tick(); bck_in = 1'b1; tick(); tick();
    end
    do_reset();
    send_word(32'h11111, 20, 0, 0);
    send_word(32'h22222, 20, 0, 0);

    for (int k = 0; k < 40; k++) begin
      int r;
      int nb;
      r  = $urandom_range(0, 9);
      nb = (r == 0) ? 19 : (r == 1) ? 21 : 20;
      send_word($urandom, nb, (nb == 20) && ($urandom_range(0, 1) == 1), 0);
    end

`ifdef PCM1702_CAPTURE_PEAK_EN
    do_reset();
    send_word(32'h00000, 20, 0, 0);
    send_word(32'h00100, 20, 0, 0);
    send_word(32'h80000, 20, 0, 0);
    send_word(32'h00010, 20, 0, 0);
    chk("peak_abs", peak_abs, 19'h7FFFF);
    peak_clr = 1'b1; tick(); peak_clr = 1'b0; tick();
    chk("peak_clr", peak_abs, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
